// File: rtl/riscv_pkg.sv
// Shared writeback types: register-file geometry and the queued result entry.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_SRC    = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;
endpackage

// File: rtl/wb_fifo.sv
// Per-source result queue; head is presented combinationally on dout_o.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  wb_entry_t     din_i,
  input  logic          pop_i,
  output wb_entry_t     dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin merge of ALU and LSU results onto the register file write port.
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
  localparam int PEND_W    = $clog2(2 * FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic [REG_ADDR_W-1:0] wr_reg_num,
  output logic                  write_en,
  output logic [XLEN-1:0]       write_data,
  output logic [PEND_W-1:0]     pending,
  output logic                  idle
);
  localparam int NS = riscv_pkg::NUM_SRC;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [NS-1:0]                src_valid, push, pop, full, empty;
  riscv_pkg::wb_entry_t [NS-1:0] src_in, head;
  logic [NS-1:0][CW-1:0]        cnt;

  riscv_pkg::src_e       prio_q, prio_d, gsel;
  logic                  gvld;
  logic                  wen_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;

  assign src_valid = {lsu_valid, alu_valid};
  assign src_in[0] = '{rd: alu_rd, data: alu_data};
  assign src_in[1] = '{rd: lsu_rd, data: lsu_data};
  assign alu_ready = !full[0];
  assign lsu_ready = !full[1];

  // x0 results complete the handshake but are never queued.
  for (genvar s = 0; s < NS; s++) begin : g_src
    assign push[s] = src_valid[s] && !full[s] && (src_in[s].rd != '0);
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[s]),
      .din_i   (src_in[s]),
      .pop_i   (pop[s]),
      .dout_o  (head[s]),
      .full_o  (full[s]),
      .empty_o (empty[s]),
      .count_o (cnt[s])
    );
  end

  always_comb begin
    gvld = |(~empty);
    gsel = prio_q;
    if (!empty[0] && empty[1]) gsel = riscv_pkg::SRC_ALU;
    else if (empty[0] && !empty[1]) gsel = riscv_pkg::SRC_LSU;
    pop = '0;
    if (gvld) pop[gsel] = 1'b1;
    prio_d = gvld ? riscv_pkg::src_e'(~gsel) : prio_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= riscv_pkg::SRC_ALU;
      wen_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      prio_q <= prio_d;
      wen_q  <= gvld;
      if (gvld) begin
        rd_q   <= head[gsel].rd;
        data_q <= head[gsel].data;
      end
    end
  end

  assign wr_reg_num = rd_q;
  assign write_en   = wen_q;
  assign write_data = data_q;
  assign pending    = PEND_W'(cnt[0]) + PEND_W'(cnt[1]);
  assign idle       = (&empty) && !wen_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: each task drives one scenario and checks inline.
module tb_writeback_arbiter;
  localparam int FD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, wr_reg_num;
  logic [31:0] alu_data, lsu_data, write_data;
  logic        write_en, idle;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t log_q[$];

  logic       alu_rdy_tr [256];
  logic       lsu_rdy_tr [256];
  logic [2:0] pend_tr    [256];
  logic       drive_to;
  logic [31:0] rf_model [32];

  always #5 clk = ~clk;

  writeback_arbiter #(.FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wr_reg_num(wr_reg_num), .write_en(write_en), .write_data(write_data),
    .pending(pending), .idle(idle)
  );

  // What the register file would capture: one entry per cycle write_en is high.
  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b1 && write_en === 1'b1) log_q.push_back('{wr_reg_num, write_data, cyc});
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
  endtask

  task automatic reset_dut;
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    log_q.delete();
  endtask

  task automatic drive_streams(input int na, input int nl, input logic [4:0] abase,
                               input logic [4:0] lbase, input logic [31:0] adbase,
                               input logic [31:0] ldbase);
    int  ai = 0;
    int  li = 0;
    int  k  = 0;
    logic a_acc, l_acc;
    while ((ai < na || li < nl) && k < 200) begin
      alu_valid = (ai < na);
      alu_rd    = 5'(abase + 5'(ai));
      alu_data  = adbase + 32'(ai);
      lsu_valid = (li < nl);
      lsu_rd    = 5'(lbase + 5'(li));
      lsu_data  = ldbase + 32'(li);
      if (k < 256) begin
        alu_rdy_tr[k] = alu_ready;
        lsu_rdy_tr[k] = lsu_ready;
        pend_tr[k]    = pending;
      end
      a_acc = alu_valid && alu_ready;
      l_acc = lsu_valid && lsu_ready;
      step();
      if (a_acc) ai++;
      if (l_acc) li++;
      k++;
    end
    clear_inputs();
    drive_to = (k >= 200);
  endtask

  task automatic wait_idle(output logic to);
    int n = 0;
    while (idle !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    to = (n >= 50);
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    step();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", write_en); end
    checks++; if (wr_reg_num !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", wr_reg_num); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", write_data); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    rst_n = 1'b1;
    step();
    checks++; if ({alu_ready, lsu_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", {alu_ready, lsu_ready}); end
    // Build up two queued entries with a write in flight, then reset mid-cycle.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    step();
    lsu_valid = 1'b0; alu_rd = 5'd6; alu_data = 32'h66;
    step();
    clear_inputs();
    checks++; if (pending !== 3'd2) begin errors++; $display("FAIL midrst_pre_pending got %0d want 2", pending); end
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_wen got %b want 1", write_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL midrst_pending got %0d want 0", pending); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL midrst_wen got %b want 0", write_en); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle got %b want 1", idle); end
    log_q.delete();
    step();
    rst_n = 1'b1;
    #1;
    checks++; if ({alu_ready, lsu_ready} !== 2'b11) begin errors++; $display("FAIL midrst_ready got %b want 11", {alu_ready, lsu_ready}); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL midrst_stale got %0d writes want 0", log_q.size()); end
  endtask

  task automatic test_single_alu;
    reset_dut();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    clear_inputs();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL single_early_wen got %b want 0", write_en); end
    checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pending got %0d want 1", pending); end
    step();
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL single_wen got %b want 1", write_en); end
    checks++; if (wr_reg_num !== 5'd5) begin errors++; $display("FAIL single_rd got %0d want 5", wr_reg_num); end
    checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h want deadbeef", write_data); end
    step();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL single_oneshot got %b want 0", write_en); end
    checks++; if (wr_reg_num !== 5'd5) begin errors++; $display("FAIL single_hold_rd got %0d want 5", wr_reg_num); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b want 1", idle); end
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", log_q.size()); end
  endtask

  task automatic test_contention;
    logic to;
    logic [4:0]  erd;
    logic [31:0] edata;
    reset_dut();
    drive_streams(4, 4, 5'd1, 5'd17, 32'h100, 32'h200);
    checks++; if (drive_to !== 1'b0) begin errors++; $display("FAIL cont_drive_timeout got %b want 0", drive_to); end
    wait_idle(to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL cont_idle_timeout got %b want 0", to); end
    checks++; if (log_q.size() != 8) begin errors++; $display("FAIL cont_count got %0d want 8", log_q.size()); end
    for (int i = 0; i < log_q.size() && i < 8; i++) begin
      erd   = (i % 2 == 0) ? 5'(1 + i / 2) : 5'(17 + i / 2);
      edata = (i % 2 == 0) ? 32'(32'h100 + i / 2) : 32'(32'h200 + i / 2);
      checks++;
      if (log_q[i].rd !== erd || log_q[i].data !== edata) begin
        errors++;
        $display("FAIL cont_grant%0d got rd=%0d data=%h want rd=%0d data=%h", i, log_q[i].rd, log_q[i].data, erd, edata);
      end
      if (i > 0) begin
        checks++;
        if (log_q[i].cyc != log_q[i-1].cyc + 1) begin
          errors++;
          $display("FAIL cont_gap%0d got cycle %0d want %0d", i, log_q[i].cyc, log_q[i-1].cyc + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic to;
    int   na, nl;
    reset_dut();
    drive_streams(4, 3, 5'd1, 5'd17, 32'h300, 32'h400);
    checks++; if (drive_to !== 1'b0) begin errors++; $display("FAIL bp_drive_timeout got %b want 0", drive_to); end
    checks++; if (lsu_rdy_tr[1] !== 1'b1) begin errors++; $display("FAIL bp_lsu_ready1 got %b want 1", lsu_rdy_tr[1]); end
    checks++; if (lsu_rdy_tr[2] !== 1'b0) begin errors++; $display("FAIL bp_lsu_ready2 got %b want 0", lsu_rdy_tr[2]); end
    checks++; if (alu_rdy_tr[2] !== 1'b1) begin errors++; $display("FAIL bp_alu_ready2 got %b want 1", alu_rdy_tr[2]); end
    checks++; if (pend_tr[2] !== 3'd3) begin errors++; $display("FAIL bp_pending2 got %0d want 3", pend_tr[2]); end
    wait_idle(to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_idle_timeout got %b want 0", to); end
    checks++; if (log_q.size() != 7) begin errors++; $display("FAIL bp_count got %0d want 7", log_q.size()); end
    na = 0; nl = 0;
    foreach (log_q[i]) begin
      checks++;
      if (log_q[i].rd < 5'd17) begin
        if (log_q[i].rd !== 5'(1 + na) || log_q[i].data !== 32'(32'h300 + na)) begin
          errors++;
          $display("FAIL bp_alu_order%0d got rd=%0d data=%h want rd=%0d data=%h", na, log_q[i].rd, log_q[i].data, 1 + na, 32'h300 + na);
        end
        na++;
      end else begin
        if (log_q[i].rd !== 5'(17 + nl) || log_q[i].data !== 32'(32'h400 + nl)) begin
          errors++;
          $display("FAIL bp_lsu_order%0d got rd=%0d data=%h want rd=%0d data=%h", nl, log_q[i].rd, log_q[i].data, 17 + nl, 32'h400 + nl);
        end
        nl++;
      end
    end
    checks++; if (na != 4 || nl != 3) begin errors++; $display("FAIL bp_split got alu=%0d lsu=%0d want alu=4 lsu=3", na, nl); end
  endtask

  task automatic test_x0_drop;
    reset_dut();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", alu_ready); end
    step();
    clear_inputs();
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL x0_pending got %0d want 0", pending); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL x0_idle got %b want 1", idle); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL x0_write got %0d writes want 0", log_q.size()); end
  endtask

  task automatic test_same_rd;
    logic to;
    reset_dut();
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'hB;
    step();
    clear_inputs();
    wait_idle(to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL race_idle_timeout got %b want 0", to); end
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL race_count got %0d want 2", log_q.size()); end
    if (log_q.size() >= 2) begin
      checks++; if (log_q[0].data !== 32'hA) begin errors++; $display("FAIL race_first got %h want a", log_q[0].data); end
      checks++; if (log_q[1].data !== 32'hB) begin errors++; $display("FAIL race_second got %h want b", log_q[1].data); end
    end
    foreach (log_q[i]) rf_model[log_q[i].rd] = log_q[i].data;
    checks++; if (rf_model[8] !== 32'hB) begin errors++; $display("FAIL race_x8 got %h want b", rf_model[8]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_backpressure();
    test_x0_drop();
    test_same_rd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
